reflex_gate_sched: RTL and testbench
====================================

Name: reflex_gate_sched

Overview:
- Round-robin scheduler that shares one reflex_kernel_gate instance among N_REQ requesters.
- Arbitrates requests and captures the winner's operands. Drives the gate for a fixed latency, then returns the trusted verdict with the requester ID over a valid/ready response channel.
- Owns the gate's packed_const configuration word, so a new constant is applied only while no evaluation is in flight.
- Keeps saturating trusted/untrusted verdict counters.

Parameters:
N_REQ, 4, number of requesters (1..16)
ID_W, 2, width of rsp_id; must be at least clog2(N_REQ) and at least 1
CONST_W, 64, packed_const width
DT_W, 32, dt_us width
DPHI_W, 16, dphi_e4 width
QSFS_W, 16, qsfs_e4 width
GATE_LAT, 1, registered latency of the gate in cycles (1..15)
CONST_RST, 64'h0, reset value of the active constant
CNT_W, 16, verdict counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_dt_us  in  N_REQ*DT_W  flattened operands, requester i at slice i
req_dphi_e4  in  N_REQ*DPHI_W  flattened operands
req_qsfs_e4  in  N_REQ*QSFS_W  flattened operands
cfg_we  in  1  constant write strobe
cfg_const  in  CONST_W  new constant word
cfg_pending  out  1  shadow constant not yet applied
gate_packed_const  out  CONST_W  to gate
gate_dt_us  out  DT_W  to gate
gate_dphi_e4  out  DPHI_W  to gate
gate_qsfs_e4  out  QSFS_W  to gate
gate_trusted  in  1  gate verdict
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the served requester
rsp_trusted  out  1  verdict
busy  out  1  state != IDLE
cnt_clr  in  1  synchronous clear of the counters
cnt_trusted  out  CNT_W  saturating count of trusted verdicts
cnt_untrusted  out  CNT_W  saturating count of untrusted verdicts

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_trusted=0.
  - Operand regs = 0; active const = CONST_RST; cfg_pending=0; both counters 0.
  - Reset mid-operation discards any in-flight request or response.
- Gate outputs are always the captured operand regs and the active const; they are registered and never combinational from req_*.
- cfg_we at any edge loads the shadow and sets cfg_pending. A later write overwrites the shadow; the last write wins.
- States are IDLE, WAIT, RESP.
- IDLE, cfg_pending=1:
  - At the edge, copy the shadow to the active const and clear cfg_pending.
  - No grant this cycle; req_ready=0.
  - cfg_we in the same cycle re-sets pending with the new shadow value; that value is applied next IDLE cycle.
- IDLE, cfg_pending=0:
  - Grant g = first index at or after rr_ptr (wrapping) with req_valid=1.
  - req_ready[g]=1 combinationally, all other bits 0.
  - At the edge: capture slice g of the operands, rsp_id<=g, cnt<=GATE_LAT, rr_ptr<=(g+1) mod N_REQ, state<=WAIT.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- WAIT:
  - While cnt!=0, decrement cnt each edge.
  - When cnt==0, at the edge: rsp_trusted<=gate_trusted, rsp_valid<=1, state<=RESP, and increment the matching counter.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - When rsp_valid&rsp_ready at the edge: rsp_valid<=0, state<=IDLE.
- Latency: the acceptance edge is E0; rsp_valid is high after edge E0+GATE_LAT+1.
- Throughput is at most one evaluation per GATE_LAT+3 cycles.
- Requester rules: hold req_valid and operands stable until req_ready. Operands are sampled only at the handshake edge. Deasserting valid before grant is legal and has no side effects.
- Counters:
  - Saturate at all-ones.
  - cnt_clr zeroes both counters and has priority over an increment at the same edge.
- N_REQ=1: rr_ptr stays 0.

Test Plan:
- GATE_LAT=1, req_valid=4'b0100, dt=100, gate stub returns trusted=1 -> req_ready=4'b0100 for one cycle; rsp_valid 2 cycles after accept with rsp_id=2, rsp_trusted=1; cnt_trusted=1.
- req_valid=4'b1111 held for 4 rounds with rsp_ready=1 -> rsp_id sequence 0,1,2,3; then 0 again (wrap); no requester starved.
- rsp_ready=0 for 5 cycles in RESP, new requests pending -> rsp_* stable, req_ready=0 throughout; after rsp_ready, next grant follows the RR order.
- cfg_we with 0xDEAD while in WAIT -> gate_packed_const unchanged until IDLE; one IDLE cycle with req_ready=0, then const=0xDEAD and cfg_pending=0; two back-to-back writes apply only the second.
- rst_n pulsed low during WAIT -> all outputs return to reset values immediately; no response is emitted for the aborted request.
- Counter at 16'hFFFF with another trusted verdict -> stays FFFF; cnt_clr coincident with an increment -> 0.

Source files
------------

// File: rtl/reflex_gate_sched.sv
// Round-robin scheduler that shares one reflex_kernel_gate among N_REQ requesters.
// Constant updates are deferred to IDLE, and trusted/untrusted verdicts are counted with saturation.
module reflex_gate_sched #(
    parameter int                 N_REQ     = 4,
    parameter int                 ID_W      = 2,
    parameter int                 CONST_W   = 64,
    parameter int                 DT_W      = 32,
    parameter int                 DPHI_W    = 16,
    parameter int                 QSFS_W    = 16,
    parameter int                 GATE_LAT  = 1,
    parameter logic [CONST_W-1:0] CONST_RST = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DT_W-1:0]      req_dt_us,
    input  logic [N_REQ*DPHI_W-1:0]    req_dphi_e4,
    input  logic [N_REQ*QSFS_W-1:0]    req_qsfs_e4,
    input  logic                       cfg_we,
    input  logic [CONST_W-1:0]         cfg_const,
    output logic                       cfg_pending,
    output logic [CONST_W-1:0]         gate_packed_const,
    output logic [DT_W-1:0]            gate_dt_us,
    output logic [DPHI_W-1:0]          gate_dphi_e4,
    output logic [QSFS_W-1:0]          gate_qsfs_e4,
    input  logic                       gate_trusted,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_trusted,
    output logic                       busy,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           cnt_trusted,
    output logic [CNT_W-1:0]           cnt_untrusted
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [LAT_W-1:0]   lat_cnt;
    logic [CONST_W-1:0] shadow_const;
    logic [CONST_W-1:0] active_const;
    logic [DT_W-1:0]    op_dt;
    logic [DPHI_W-1:0]  op_dphi;
    logic [QSFS_W-1:0]  op_qsfs;

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   cand_idx;
    int                 cand;

    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = PTR_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        next_ptr = '0;
        if (grant_idx != PTR_W'(N_REQ - 1)) next_ptr = grant_idx + 1'b1;
    end

    // A pending constant takes the IDLE cycle, so no grant is offered then.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !cfg_pending && grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign gate_packed_const = active_const;
    assign gate_dt_us        = op_dt;
    assign gate_dphi_e4      = op_dphi;
    assign gate_qsfs_e4      = op_qsfs;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lat_cnt       <= '0;
            shadow_const  <= CONST_RST;
            active_const  <= CONST_RST;
            cfg_pending   <= 1'b0;
            op_dt         <= '0;
            op_dphi       <= '0;
            op_qsfs       <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_trusted   <= 1'b0;
            cnt_trusted   <= '0;
            cnt_untrusted <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_pending) begin
                        active_const <= shadow_const;
                        cfg_pending  <= 1'b0;
                    end else if (grant_any) begin
                        op_dt   <= req_dt_us[grant_idx*DT_W +: DT_W];
                        op_dphi <= req_dphi_e4[grant_idx*DPHI_W +: DPHI_W];
                        op_qsfs <= req_qsfs_e4[grant_idx*QSFS_W +: QSFS_W];
                        rsp_id  <= ID_W'(grant_idx);
                        lat_cnt <= LAT_W'(GATE_LAT);
                        rr_ptr  <= next_ptr;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        rsp_trusted <= gate_trusted;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // NOTE: non-blocking updates let this later write override the IDLE clear above.
            if (cfg_we) begin
                shadow_const <= cfg_const;
                cfg_pending  <= 1'b1;
            end

            if (cnt_clr) begin
                cnt_trusted   <= '0;
                cnt_untrusted <= '0;
            end else if (state == WAIT && lat_cnt == '0) begin
                if (gate_trusted) begin
                    if (cnt_trusted != '1) cnt_trusted <= cnt_trusted + 1'b1;
                end else begin
                    if (cnt_untrusted != '1) cnt_untrusted <= cnt_untrusted + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reflex_gate_sched.sv
// Self-checking bench for reflex_gate_sched: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_reflex_gate_sched;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int CONST_W  = 64;
    localparam int DT_W     = 32;
    localparam int DPHI_W   = 16;
    localparam int QSFS_W   = 16;
    localparam int GATE_LAT = 1;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0]            req_valid = '0;
    logic [N-1:0]            req_ready;
    logic [N*DT_W-1:0]       req_dt_us = '0;
    logic [N*DPHI_W-1:0]     req_dphi_e4 = '0;
    logic [N*QSFS_W-1:0]     req_qsfs_e4 = '0;
    logic                    cfg_we = 1'b0;
    logic [CONST_W-1:0]      cfg_const = '0;
    logic                    cfg_pending;
    logic [CONST_W-1:0]      gate_packed_const;
    logic [DT_W-1:0]         gate_dt_us;
    logic [DPHI_W-1:0]       gate_dphi_e4;
    logic [QSFS_W-1:0]       gate_qsfs_e4;
    logic                    gate_trusted = 1'b0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_trusted;
    logic                    busy;
    logic                    cnt_clr = 1'b0;
    logic [CNT_W-1:0]        cnt_trusted;
    logic [CNT_W-1:0]        cnt_untrusted;

    int n_checks = 0;
    int n_fail   = 0;

    reflex_gate_sched #(
        .N_REQ(N), .ID_W(ID_W), .CONST_W(CONST_W), .DT_W(DT_W), .DPHI_W(DPHI_W),
        .QSFS_W(QSFS_W), .GATE_LAT(GATE_LAT), .CONST_RST(64'h0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dt_us(req_dt_us), .req_dphi_e4(req_dphi_e4), .req_qsfs_e4(req_qsfs_e4),
        .cfg_we(cfg_we), .cfg_const(cfg_const), .cfg_pending(cfg_pending),
        .gate_packed_const(gate_packed_const), .gate_dt_us(gate_dt_us),
        .gate_dphi_e4(gate_dphi_e4), .gate_qsfs_e4(gate_qsfs_e4),
        .gate_trusted(gate_trusted),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_trusted(rsp_trusted), .busy(busy),
        .cnt_clr(cnt_clr), .cnt_trusted(cnt_trusted), .cnt_untrusted(cnt_untrusted)
    );

    always #5 clk = ~clk;

    // Gate stand-in: trusted when the operand/constant sum is even, one registered stage.
    function automatic logic stub_f(logic [31:0] dt, logic [15:0] dphi, logic [15:0] qsfs,
                                    logic [63:0] k);
        logic [31:0] sum;
        sum = dt + 32'(dphi) + 32'(qsfs) + k[31:0];
        return ~sum[0];
    endfunction

    always @(posedge clk)
        gate_trusted <= stub_f(gate_dt_us, gate_dphi_e4, gate_qsfs_e4, gate_packed_const);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] dt, input logic [15:0] dphi,
                           input logic [15:0] qsfs);
        req_dt_us[i*DT_W +: DT_W]       = dt;
        req_dphi_e4[i*DPHI_W +: DPHI_W] = dphi;
        req_qsfs_e4[i*QSFS_W +: QSFS_W] = qsfs;
    endtask

    task automatic check_reset_values();
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_id", rsp_id, 0);
        check("rst rsp_trusted", rsp_trusted, 0);
        check("rst busy", busy, 0);
        check("rst cfg_pending", cfg_pending, 0);
        check("rst const", gate_packed_const, 64'h0);
        check("rst gate_dt", gate_dt_us, 0);
        check("rst cnt_trusted", cnt_trusted, 0);
        check("rst cnt_untrusted", cnt_untrusted, 0);
    endtask

    task automatic do_reset();
        req_valid   = '0;
        rsp_ready   = 1'b0;
        cfg_we      = 1'b0;
        cnt_clr     = 1'b0;
        req_dt_us   = '0;
        req_dphi_e4 = '0;
        req_qsfs_e4 = '0;
        rst_n       = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Grant, latency-agnostic wait and handshake of one request; caller supplies the expectations.
    task automatic serve(input int exp_id, input logic exp_tr);
        int t;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            tick();
            t++;
        end
        check("serve grant", req_ready, 64'(1) << exp_id);
        tick();
        req_valid[exp_id] = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin
            tick();
            t++;
        end
        check("serve rsp_valid", rsp_valid, 1);
        check("serve rsp_id", rsp_id, exp_id);
        check("serve rsp_trusted", rsp_trusted, exp_tr);
        rsp_ready = 1'b1;
        tick();
        check("serve consumed", rsp_valid, 0);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [31:0]  dt;
        logic [15:0]  dphi;
        logic [15:0]  qsfs;
        int           exp_id;
        logic         exp_tr;
    } vec_t;

    vec_t vecs[8];

    // Reference-model state for the randomized run.
    logic [N-1:0]  rv;
    logic [31:0]   r_dt[N];
    logic [15:0]   r_dphi[N];
    logic [15:0]   r_qsfs[N];
    bit            m_inflight, m_rspv, m_pend;
    int            m_resp_at, m_ptr, m_id, m_ct, m_cu, granted, exp_g;
    logic          m_tr, m_verdict;
    logic [63:0]   m_active, m_shadow;
    logic [31:0]   m_dt;
    logic [15:0]   m_dphi, m_qsfs;

    initial begin
        vecs[0] = '{4'b0100, 32'd100, 16'd0, 16'd0, 2, 1'b1};
        vecs[1] = '{4'b0011, 32'd7,   16'd0, 16'd0, 0, 1'b0};
        vecs[2] = '{4'b0011, 32'd8,   16'd0, 16'd0, 1, 1'b1};
        vecs[3] = '{4'b1001, 32'd0,   16'd1, 16'd0, 3, 1'b0};
        vecs[4] = '{4'b1000, 32'd2,   16'd0, 16'd0, 3, 1'b1};
        vecs[5] = '{4'b0001, 32'd0,   16'd0, 16'd3, 0, 1'b0};
        vecs[6] = '{4'b1110, 32'd4,   16'd0, 16'd0, 1, 1'b1};
        vecs[7] = '{4'b0101, 32'd10,  16'd2, 16'd0, 2, 1'b1};

        do_reset();

        // Exact-latency vectors; losing slices get dt+1 so a wrong slice flips the verdict.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++)
                set_ops(i, (i == vecs[v].exp_id) ? vecs[v].dt : vecs[v].dt + 1,
                        vecs[v].dphi, vecs[v].qsfs);
            req_valid = vecs[v].mask;
            rsp_ready = 1'b1;
            #1;
            check("vec grant", req_ready, 64'(1) << vecs[v].exp_id);
            tick();
            req_valid = '0;
            check("vec gate_dt", gate_dt_us, vecs[v].dt);
            check("vec busy", busy, 1);
            repeat (GATE_LAT) tick();
            check("vec early rsp", rsp_valid, 0);
            tick();
            check("vec rsp_valid", rsp_valid, 1);
            check("vec rsp_id", rsp_id, vecs[v].exp_id);
            check("vec rsp_trusted", rsp_trusted, vecs[v].exp_tr);
            tick();
            check("vec consumed", rsp_valid, 0);
            check("vec idle", busy, 0);
        end
        check("vec cnt_trusted", cnt_trusted, 5);
        check("vec cnt_untrusted", cnt_untrusted, 3);

        // Round robin with all requesters asserting for five rounds.
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 32'(2 * i), 16'd0, 16'd0);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            serve(r % N, 1'b1);
            req_valid[r % N] = 1'b1;
        end

        // Response backpressure with new requests pending.
        rsp_ready = 1'b0;
        #1;
        check("bp grant", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        repeat (GATE_LAT + 1) tick();
        check("bp rsp_valid", rsp_valid, 1);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp hold valid", rsp_valid, 1);
            check("bp hold id", rsp_id, 1);
            check("bp hold trusted", rsp_trusted, 1);
            check("bp no grant", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp released", rsp_valid, 0);
        serve(2, 1'b1);
        req_valid = '0;

        // Constant write during WAIT is deferred to the next IDLE cycle.
        for (int i = 0; i < N; i++) set_ops(i, 32'd100, 16'd0, 16'd0);
        req_valid = 4'b1000;
        #1;
        check("cfg grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        cfg_we    = 1'b1;
        cfg_const = 64'hDEAD;
        tick();
        cfg_we = 1'b0;
        check("cfg pending in WAIT", cfg_pending, 1);
        check("cfg const held", gate_packed_const, 64'h0);
        rsp_ready = 1'b0;
        tick();
        check("cfg rsp_valid", rsp_valid, 1);
        check("cfg old verdict", rsp_trusted, 1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        check("cfg no grant in RESP", req_ready, 0);
        tick();
        check("cfg apply cycle no grant", req_ready, 0);
        check("cfg apply cycle const", gate_packed_const, 64'h0);
        check("cfg apply cycle pending", cfg_pending, 1);
        tick();
        check("cfg applied const", gate_packed_const, 64'hDEAD);
        check("cfg applied pending", cfg_pending, 0);
        serve(0, 1'b0);

        // Back-to-back writes: only the second reaches the gate.
        for (int i = 0; i < N; i++) set_ops(i, 32'd1, 16'd0, 16'd0);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("cfg2 grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        cfg_we    = 1'b1;
        cfg_const = 64'h1111;
        tick();
        cfg_const = 64'h2222;
        tick();
        cfg_we = 1'b0;
        check("cfg2 const held", gate_packed_const, 64'hDEAD);
        check("cfg2 pending", cfg_pending, 1);
        check("cfg2 verdict", rsp_trusted, 1);
        rsp_ready = 1'b1;
        tick();
        check("cfg2 apply cycle const", gate_packed_const, 64'hDEAD);
        tick();
        check("cfg2 last write wins", gate_packed_const, 64'h2222);
        check("cfg2 pending cleared", cfg_pending, 0);

        // Asynchronous reset during WAIT aborts the request.
        req_valid = 4'b0100;
        #1;
        check("rstw grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("rstw busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < GATE_LAT + 4; c++) begin
            tick();
            check("rstw no response", rsp_valid, 0);
        end

        // Counter saturation and clear priority.
        do_reset();
        rsp_ready = 1'b1;
        set_ops(0, 32'd0, 16'd0, 16'd0);
        for (int c = 0; c < SAT; c++) begin
            req_valid[0] = 1'b1;
            serve(0, 1'b1);
        end
        check("cnt reaches max", cnt_trusted, SAT);
        req_valid[0] = 1'b1;
        serve(0, 1'b1);
        check("cnt saturates", cnt_trusted, SAT);
        set_ops(0, 32'd1, 16'd0, 16'd0);
        req_valid[0] = 1'b1;
        serve(0, 1'b0);
        check("cnt untrusted", cnt_untrusted, 1);
        set_ops(0, 32'd0, 16'd0, 16'd0);
        req_valid[0] = 1'b1;
        #1;
        tick();
        req_valid[0] = 1'b0;
        repeat (GATE_LAT) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr rsp_valid", rsp_valid, 1);
        check("clr beats inc trusted", cnt_trusted, 0);
        check("clr untrusted", cnt_untrusted, 0);
        tick();

        // Randomized run against the transaction-level model.
        do_reset();
        rv = '0;
        for (int i = 0; i < N; i++) begin
            r_dt[i] = 0; r_dphi[i] = 0; r_qsfs[i] = 0;
        end
        m_inflight = 0; m_rspv = 0; m_pend = 0; m_resp_at = 0; m_ptr = 0; m_id = 0;
        m_ct = 0; m_cu = 0; granted = -1; m_tr = 0; m_verdict = 0;
        m_active = 64'h0; m_shadow = 64'h0; m_dt = 0; m_dphi = 0; m_qsfs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit idle;
            for (int i = 0; i < N; i++) begin
                if (i == granted) begin
                    rv[i] = 1'b0;
                end else if (!rv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rv[i]     = 1'b1;
                        r_dt[i]   = $urandom;
                        r_dphi[i] = 16'($urandom);
                        r_qsfs[i] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    rv[i] = 1'b0;
                end
                set_ops(i, r_dt[i], r_dphi[i], r_qsfs[i]);
            end
            req_valid = rv;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 24) == 0);
            cfg_const = {$urandom, $urandom};
            cnt_clr   = ($urandom_range(0, 99) == 0);
            #1;

            idle  = !m_inflight && !m_rspv;
            exp_g = -1;
            if (idle && !m_pend)
                for (int k = 0; k < N; k++)
                    if (exp_g < 0 && rv[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;

            check("rnd req_ready", req_ready, (exp_g >= 0) ? (64'(1) << exp_g) : 64'(0));
            check("rnd rsp_valid", rsp_valid, m_rspv);
            check("rnd rsp_id", rsp_id, m_id);
            check("rnd rsp_trusted", rsp_trusted, m_tr);
            check("rnd busy", busy, !idle);
            check("rnd cfg_pending", cfg_pending, m_pend);
            check("rnd const", gate_packed_const, m_active);
            check("rnd gate_dt", gate_dt_us, m_dt);
            check("rnd gate_dphi", gate_dphi_e4, m_dphi);
            check("rnd gate_qsfs", gate_qsfs_e4, m_qsfs);
            check("rnd cnt_trusted", cnt_trusted, m_ct);
            check("rnd cnt_untrusted", cnt_untrusted, m_cu);

            granted = exp_g;
            if (m_rspv) begin
                if (rsp_ready) m_rspv = 0;
            end else if (m_inflight) begin
                if (cyc == m_resp_at) begin
                    m_inflight = 0;
                    m_rspv     = 1;
                    m_tr       = m_verdict;
                    if (m_verdict) m_ct = (m_ct == SAT) ? SAT : m_ct + 1;
                    else           m_cu = (m_cu == SAT) ? SAT : m_cu + 1;
                end
            end else if (m_pend) begin
                m_active = m_shadow;
                m_pend   = 0;
            end else if (exp_g >= 0) begin
                m_inflight = 1;
                m_resp_at  = cyc + GATE_LAT + 1;
                m_id       = exp_g;
                m_dt       = r_dt[exp_g];
                m_dphi     = r_dphi[exp_g];
                m_qsfs     = r_qsfs[exp_g];
                m_verdict  = stub_f(m_dt, m_dphi, m_qsfs, m_active);
                m_ptr      = (exp_g + 1) % N;
            end
            if (cnt_clr) begin
                m_ct = 0;
                m_cu = 0;
            end
            if (cfg_we) begin
                m_shadow = cfg_const;
                m_pend   = 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
